// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register and its transmit sequencer:
// register select codes, the sequencer state enum and a counter-width helper.
package usr_pkg;

  localparam logic [1:0] USR_HOLD = 2'd0;
  localparam logic [1:0] USR_SHR  = 2'd1;
  localparam logic [1:0] USR_SHL  = 2'd2;
  localparam logic [1:0] USR_LOAD = 2'd3;

  typedef enum logic {
    USR_IDLE  = 1'b0,
    USR_SHIFT = 1'b1
  } usr_state_t;

  // Bit-index counter width; keeps a 1-bit counter legal for degenerate widths.
  function automatic int usr_cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/usr_shift_reg.sv
// Universal shift register: hold, shift right, shift left or parallel load
// under a 2-bit select. Serial outputs come straight from the register flops.
module usr_shift_reg
  import usr_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       select,
  input  logic [WIDTH-1:0] p_din,
  input  logic             s_left_din,
  input  logic             s_right_din,
  output logic [WIDTH-1:0] p_dout,
  output logic             left_dout,
  output logic             right_dout
);

  logic [WIDTH-1:0] q;

  // NOTE: this is a register bank, not a RAM, so it takes the async reset
  // like any other flop; reset also makes abandoned words disappear cleanly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      case (select)
        USR_SHR:  q <= {s_left_din, q[WIDTH-1:1]};
        USR_SHL:  q <= {q[WIDTH-2:0], s_right_din};
        USR_LOAD: q <= p_din;
        default:  q <= q;
      endcase
    end
  end

  assign p_dout     = q;
  assign left_dout  = q[WIDTH-1];
  assign right_dout = q[0];

endmodule

// File: rtl/usr_tx_sequencer.sv
// Serialising sequencer: loads accepted words into the universal shift register
// and walks them out one bit per downstream handshake, LSB or MSB first.
module usr_tx_sequencer
  import usr_pkg::*;
#(
  parameter int   WIDTH = 4,
  parameter logic FILL  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_msb_first,
  output logic             in_ready,
  output logic [1:0]       select,
  output logic [WIDTH-1:0] p_din,
  output logic             s_left_din,
  output logic             s_right_din,
  input  logic             usr_right_dout,
  input  logic             usr_left_dout,
  output logic             tx_valid,
  output logic             tx_bit,
  output logic             tx_last,
  input  logic             tx_ready,
  output logic             busy
);

  localparam int             CW       = usr_cnt_width(WIDTH);
  localparam logic [CW-1:0]  LAST_IDX = CW'(WIDTH - 1);

  usr_state_t    state, state_next;
  logic          dir, dir_next;
  logic [CW-1:0] bit_cnt, bit_cnt_next;

  // NOTE: state flops use non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= USR_IDLE;
      dir     <= 1'b0;
      bit_cnt <= '0;
    end else begin
      state   <= state_next;
      dir     <= dir_next;
      bit_cnt <= bit_cnt_next;
    end
  end

  // NOTE: every output of this block is defaulted first so no path through
  // the case statement can leave a variable unassigned and infer a latch.
  always_comb begin
    state_next   = state;
    dir_next     = dir;
    bit_cnt_next = bit_cnt;
    select       = USR_HOLD;
    in_ready     = 1'b0;
    tx_valid     = 1'b0;
    tx_bit       = 1'b0;
    tx_last      = 1'b0;

    case (state)
      USR_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          select       = USR_LOAD;
          dir_next     = in_msb_first;
          bit_cnt_next = '0;
          state_next   = USR_SHIFT;
        end
      end

      USR_SHIFT: begin
        tx_valid = 1'b1;
        tx_bit   = dir ? usr_left_dout : usr_right_dout;
        tx_last  = (bit_cnt == LAST_IDX);
        in_ready = tx_ready && tx_last;
        if (tx_ready) begin
          if (tx_last && in_valid) begin
            // Reload on the final bit keeps the stream bubble-free.
            select       = USR_LOAD;
            dir_next     = in_msb_first;
            bit_cnt_next = '0;
          end else if (tx_last) begin
            select     = dir ? USR_SHL : USR_SHR;
            state_next = USR_IDLE;
          end else begin
            select       = dir ? USR_SHL : USR_SHR;
            bit_cnt_next = bit_cnt + 1'b1;
          end
        end
      end

      default: state_next = USR_IDLE;
    endcase
  end

  assign p_din       = in_data;
  assign s_left_din  = FILL;
  assign s_right_din = FILL;
  assign busy        = (state == USR_SHIFT);

endmodule

// File: tb/tb_usr_tx_sequencer.sv
// Bench for usr_tx_sequencer wired to usr_shift_reg: directed vector table,
// a hand-written back-to-back MSB-first sequence and a randomized model run.
module tb_usr_tx_sequencer;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_msb_first;
  logic         in_ready;
  logic [1:0]   select;
  logic [W-1:0] p_din;
  logic         s_left_din, s_right_din;
  logic         usr_right_dout, usr_left_dout;
  logic         tx_valid, tx_bit, tx_last, tx_ready, busy;
  logic [W-1:0] p_dout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  usr_tx_sequencer #(.WIDTH(W), .FILL(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_msb_first(in_msb_first),
    .in_ready(in_ready), .select(select), .p_din(p_din),
    .s_left_din(s_left_din), .s_right_din(s_right_din),
    .usr_right_dout(usr_right_dout), .usr_left_dout(usr_left_dout),
    .tx_valid(tx_valid), .tx_bit(tx_bit), .tx_last(tx_last),
    .tx_ready(tx_ready), .busy(busy)
  );

  usr_shift_reg #(.WIDTH(W)) sreg (
    .clk(clk), .rst_n(rst_n), .select(select), .p_din(p_din),
    .s_left_din(s_left_din), .s_right_din(s_right_din),
    .p_dout(p_dout), .left_dout(usr_left_dout), .right_dout(usr_right_dout)
  );

  typedef struct packed {
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] data;
    logic         msb;
    logic         tx_ready;
    logic [1:0]   sel;
    logic         txv;
    logic         tbit;
    logic         last;
    logic         rdy;
    logic         busy;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic v, input logic [W-1:0] d,
                              input logic m, input logic tr, input logic [1:0] s,
                              input logic txv, input logic b, input logic l,
                              input logic rdy, input logic bs);
    vec_t x;
    x = '{rst_n: r, in_valid: v, data: d, msb: m, tx_ready: tr, sel: s,
          txv: txv, tbit: b, last: l, rdy: rdy, busy: bs};
    return x;
  endfunction

  // Behavioural reference: the word in flight and how many bits have gone out.
  logic [W-1:0] m_word;
  logic         m_dir;
  int           m_idx;
  logic         m_active;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_msb_first = 1'b0; tx_ready = 1'b1;
    #12;
    check("reset_in_ready", in_ready, 1);
    check("reset_select",   select,   0);
    check("reset_tx_valid", tx_valid, 0);
    check("reset_tx_last",  tx_last,  0);
    check("reset_busy",     busy,     0);
    check("reset_fill",     {s_left_din, s_right_din}, 0);

    // Single word LSB first: 1101 -> 1,0,1,1
    vecs.push_back(mk(1,1,4'b1101,0,1, 3, 0,0,0, 1,0));
    vecs.push_back(mk(1,0,4'b0000,0,1, 1, 1,1,0, 0,1));
    vecs.push_back(mk(1,0,4'b0000,0,1, 1, 1,0,0, 0,1));
    vecs.push_back(mk(1,0,4'b0000,0,1, 1, 1,1,0, 0,1));
    vecs.push_back(mk(1,0,4'b0000,0,1, 1, 1,1,1, 1,1));
    vecs.push_back(mk(1,0,4'b0000,0,1, 0, 0,0,0, 1,0));
    // Single word MSB first: 1101 -> 1,1,0,1
    vecs.push_back(mk(1,1,4'b1101,1,1, 3, 0,0,0, 1,0));
    vecs.push_back(mk(1,0,4'b0000,0,1, 2, 1,1,0, 0,1));
    vecs.push_back(mk(1,0,4'b0000,0,1, 2, 1,1,0, 0,1));
    vecs.push_back(mk(1,0,4'b0000,0,1, 2, 1,0,0, 0,1));
    vecs.push_back(mk(1,0,4'b0000,0,1, 2, 1,1,1, 1,1));
    vecs.push_back(mk(1,0,4'b0000,0,1, 0, 0,0,0, 1,0));
    // Backpressure: 0110 LSB first, 3-cycle stall after first bit
    vecs.push_back(mk(1,1,4'b0110,0,1, 3, 0,0,0, 1,0));
    vecs.push_back(mk(1,0,4'b0000,0,1, 1, 1,0,0, 0,1));
    vecs.push_back(mk(1,1,4'b1111,1,0, 0, 1,1,0, 0,1));
    vecs.push_back(mk(1,0,4'b0000,0,0, 0, 1,1,0, 0,1));
    vecs.push_back(mk(1,0,4'b0000,0,0, 0, 1,1,0, 0,1));
    vecs.push_back(mk(1,0,4'b0000,0,1, 1, 1,1,0, 0,1));
    vecs.push_back(mk(1,0,4'b0000,0,1, 1, 1,1,0, 0,1));
    vecs.push_back(mk(1,0,4'b0000,0,1, 1, 1,0,1, 1,1));
    vecs.push_back(mk(1,0,4'b0000,0,1, 0, 0,0,0, 1,0));
    // Back-to-back: 1010 then 0011 LSB first -> 0,1,0,1,1,1,0,0
    vecs.push_back(mk(1,1,4'b1010,0,1, 3, 0,0,0, 1,0));
    vecs.push_back(mk(1,1,4'b0011,0,1, 1, 1,0,0, 0,1));
    vecs.push_back(mk(1,1,4'b0011,0,1, 1, 1,1,0, 0,1));
    vecs.push_back(mk(1,1,4'b0011,0,1, 1, 1,0,0, 0,1));
    vecs.push_back(mk(1,1,4'b0011,0,1, 3, 1,1,1, 1,1));
    vecs.push_back(mk(1,0,4'b0000,0,1, 1, 1,1,0, 0,1));
    vecs.push_back(mk(1,0,4'b0000,0,1, 1, 1,1,0, 0,1));
    vecs.push_back(mk(1,0,4'b0000,0,1, 1, 1,0,0, 0,1));
    vecs.push_back(mk(1,0,4'b0000,0,1, 1, 1,0,1, 1,1));
    vecs.push_back(mk(1,0,4'b0000,0,1, 0, 0,0,0, 1,0));
    // Reset mid-word: 1111, reset after 2nd bit, then 0001 -> 1,0,0,0
    vecs.push_back(mk(1,1,4'b1111,0,1, 3, 0,0,0, 1,0));
    vecs.push_back(mk(1,0,4'b0000,0,1, 1, 1,1,0, 0,1));
    vecs.push_back(mk(1,0,4'b0000,0,1, 1, 1,1,0, 0,1));
    vecs.push_back(mk(0,0,4'b0000,0,1, 0, 0,0,0, 1,0));
    vecs.push_back(mk(1,1,4'b0001,0,1, 3, 0,0,0, 1,0));
    vecs.push_back(mk(1,0,4'b0000,0,1, 1, 1,1,0, 0,1));
    vecs.push_back(mk(1,0,4'b0000,0,1, 1, 1,0,0, 0,1));
    vecs.push_back(mk(1,0,4'b0000,0,1, 1, 1,0,0, 0,1));
    vecs.push_back(mk(1,0,4'b0000,0,1, 1, 1,0,1, 1,1));
    // Idle for 10 cycles
    for (int i = 0; i < 10; i++) vecs.push_back(mk(1,0,4'b0000,0,1, 0, 0,0,0, 1,0));

    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      rst_n = vecs[i].rst_n; in_valid = vecs[i].in_valid; in_data = vecs[i].data;
      in_msb_first = vecs[i].msb; tx_ready = vecs[i].tx_ready;
      #2;
      check($sformatf("vec%0d_select", i),   select,   vecs[i].sel);
      check($sformatf("vec%0d_tx_valid", i), tx_valid, vecs[i].txv);
      if (vecs[i].txv) check($sformatf("vec%0d_tx_bit", i), tx_bit, vecs[i].tbit);
      check($sformatf("vec%0d_tx_last", i),  tx_last,  vecs[i].last);
      check($sformatf("vec%0d_in_ready", i), in_ready, vecs[i].rdy);
      check($sformatf("vec%0d_busy", i),     busy,     vecs[i].busy);
    end

    // Hand-written: MSB-first back-to-back 1001 then 0110, gap-free stream.
    begin
      logic [7:0] got;
      logic [7:0] want;
      int nbits, accepts, gaps;
      logic seen;
      want = 8'b1001_0110;
      got = '0; nbits = 0; accepts = 0; gaps = 0; seen = 1'b0;
      for (int c = 0; c < 14; c++) begin
        @(negedge clk);
        rst_n = 1'b1; tx_ready = 1'b1; in_msb_first = 1'b1;
        in_valid = (accepts < 2);
        in_data  = (accepts == 0) ? 4'b1001 : 4'b0110;
        #2;
        if (tx_valid && nbits < 8) begin
          got[7 - nbits] = tx_bit;
          nbits++;
          seen = 1'b1;
        end else if (seen && nbits < 8) begin
          gaps++;
        end
        if (in_valid && in_ready) accepts++;
      end
      check("b2b_msb_bits",  got,   want);
      check("b2b_msb_count", nbits, 8);
      check("b2b_msb_gaps",  gaps,  0);
    end

    // Randomized run against the reference model.
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    m_active = 1'b0; m_idx = 0; m_dir = 1'b0; m_word = '0;
    for (int c = 0; c < 600; c++) begin
      logic       e_rdy, e_last;
      logic [1:0] e_sel;
      @(negedge clk);
      in_valid     = ($urandom_range(1, 0) == 1);
      in_data      = W'($urandom);
      in_msb_first = ($urandom_range(1, 0) == 1);
      tx_ready     = ($urandom_range(3, 0) != 0);
      #2;
      e_last = m_active && (m_idx == W - 1);
      e_rdy  = !m_active || (tx_ready && e_last);
      if (!m_active)               e_sel = in_valid ? 2'd3 : 2'd0;
      else if (!tx_ready)          e_sel = 2'd0;
      else if (e_last && in_valid) e_sel = 2'd3;
      else                         e_sel = m_dir ? 2'd2 : 2'd1;
      check("rnd_tx_valid", tx_valid, m_active);
      check("rnd_busy",     busy,     m_active);
      check("rnd_in_ready", in_ready, e_rdy);
      check("rnd_select",   select,   e_sel);
      check("rnd_tx_last",  tx_last,  e_last);
      check("rnd_p_din",    p_din,    in_data);
      if (m_active)
        check("rnd_tx_bit", tx_bit, m_dir ? m_word[W - 1 - m_idx] : m_word[m_idx]);
      @(posedge clk);
      if (in_valid && e_rdy) begin
        m_word = in_data; m_dir = in_msb_first; m_idx = 0; m_active = 1'b1;
      end else if (m_active && tx_ready) begin
        if (m_idx == W - 1) m_active = 1'b0;
        else                m_idx++;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
